// File: rtl/serial_adder16_if.sv
// Start/busy/done handshake bundle for the bit-serial adder.
interface serial_adder16_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;

  modport master (output start, a, b, cin, sub, input busy, done, result, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, result, cout);
endinterface

// File: rtl/serial_adder16.sv
// Bit-serial ripple adder/subtractor: one full-adder cell plus carry FF, LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder16_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);
endmodule

module serial_adder16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_adder16_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, shadow, result_q;
  logic [CW-1:0]    cnt;
  logic             carry, cout_q, s, co, sub_eff, accept, last;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_eff = bus.sub;
`else
  assign sub_eff = 1'b0;
`endif

  // start is only honoured when no operation is in flight
  assign accept = bus.start && (state != RUN);
  assign last   = (cnt == CW'(WIDTH - 1));

  serial_adder16_fa u_fa (.x(sa[0]), .y(sb[0]), .ci(carry), .s(s), .co(co));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa       <= '0;
      sb       <= '0;
      shadow   <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else if (accept) begin
      sa    <= bus.a;
      sb    <= sub_eff ? ~bus.b : bus.b;
      carry <= bus.cin | sub_eff;
      cnt   <= '0;
    end else if (state == RUN) begin
      sa     <= sa >> 1;
      sb     <= sb >> 1;
      shadow <= {s, shadow[WIDTH-1:1]};
      carry  <= co;
      cnt    <= cnt + 1'b1;
      // visible outputs only ever update with the complete word
      if (last) begin
        result_q <= {s, shadow[WIDTH-1:1]};
        cout_q   <= co;
      end
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
endmodule

// File: tb/tb_serial_adder16.sv
// Self-checking bench for serial_adder16: vector table, scoreboard queue, corner sequences.
module tb_serial_adder16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder16_if #(.WIDTH(16)) bus ();
  serial_adder16 #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] er;
    logic        ec;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int n_done = 0;
  logic [16:0] sbq[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) return {1'b0, a} + {1'b0, ~b} + 17'd1;
`endif
    return {1'b0, a} + {1'b0, b} + {16'd0, cin};
  endfunction

  // scoreboard: every done pops the oldest expected result
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      n_done++;
      if (sbq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        logic [16:0] e;
        e = sbq.pop_front();
        chk("result", {15'd0, bus.cout, bus.result}, {15'd0, e});
      end
    end
  end

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic su);
    bus.a = a; bus.b = b; bus.cin = ci; bus.sub = su;
  endtask

  // single op: accept, measure busy cycles and edges until done
  task automatic do_op(input vec_t v, input string nm);
    int lat, bc;
    @(negedge clk);
    drive(v.a, v.b, v.cin, v.sub);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    drive($urandom, $urandom, $urandom_range(1), $urandom_range(1));
    sbq.push_back({v.ec, v.er});
    lat = 0; bc = 0;
    if (bus.busy) bc++;
    while (!bus.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (bus.busy) bc++;
    end
    chk({nm, "_done_seen"}, {31'd0, bus.done}, 32'd1);
    chk({nm, "_latency"}, lat, 32'd16);
    chk({nm, "_busy_cycles"}, bc, 32'd16);
  endtask

  initial begin
    vec_t tbl[9];
    int d0, lat;
    logic [15:0] ta[6], tb_[6];
    logic [15:0] keep_r;

    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[2] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0};
    tbl[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1};
    tbl[5] = '{16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0};
`ifdef SERIAL_ADDER_SUB_EN
    tbl[6] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0};
    tbl[7] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1};
    tbl[8] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0};
`else
    tbl[6] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0};
    tbl[7] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h000C, 1'b0};
    tbl[8] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'h000D, 1'b0};
`endif

    bus.start = 1'b0;
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_result", {16'd0, bus.result}, 32'd0);
    chk("rst_cout", {31'd0, bus.cout}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 9; i++) do_op(tbl[i], $sformatf("vec%0d", i));
    repeat (3) @(posedge clk);

    // T4: start pulsed mid-run with other operands is ignored
    d0 = n_done;
    @(negedge clk);
    drive(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    sbq.push_back(17'h01010);
    repeat (5) @(posedge clk);
    @(negedge clk);
    drive(16'h7777, 16'h1111, 1'b1, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("ignore_start_dones", n_done - d0, 32'd1);
    chk("ignore_start_held", {16'd0, bus.result}, 32'h1010);

    // T5: async reset mid-run aborts with no done
    @(negedge clk);
    drive(16'h2222, 16'h3333, 1'b0, 1'b0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_result", {16'd0, bus.result}, 32'd0);
    chk("abort_cout", {31'd0, bus.cout}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    d0 = n_done;
    repeat (30) @(posedge clk);
    #1;
    chk("abort_no_done", n_done - d0, 32'd0);

    // T6: start held high, new operands on every accept
    for (int k = 0; k < 6; k++) begin
      ta[k] = 16'($urandom);
      tb_[k] = 16'($urandom);
    end
    ta[0] = 16'hFFFF; tb_[0] = 16'hFFFF;
    @(negedge clk);
    drive(ta[0], tb_[0], 1'b1, 1'b0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    sbq.push_back(model(ta[0], tb_[0], 1'b1, 1'b0));
    drive(ta[1], tb_[1], 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      lat = 0;
      while (!bus.done && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("b2b_latency", lat, 32'd16);
      chk("b2b_busy_in_done", {31'd0, bus.busy}, 32'd0);
      keep_r = bus.result;
      if (k == 6) bus.start = 1'b0;
      @(posedge clk); #1;
      if (k < 6) begin
        chk("b2b_reaccept_busy", {30'd0, bus.busy, bus.done}, 32'd2);
        chk("b2b_result_hold", {16'd0, bus.result}, {16'd0, keep_r});
        sbq.push_back(model(ta[k], tb_[k], 1'b0, 1'b0));
        if (k < 5) drive(ta[k+1], tb_[k+1], 1'b0, 1'b0);
      end else begin
        chk("b2b_final_idle", {30'd0, bus.busy, bus.done}, 32'd0);
      end
    end

    repeat (3) @(posedge clk);
    chk("sb_drain", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
